serial_subtractor_ctrl: RTL and testbench
=========================================

# serial_subtractor_ctrl

Bit-serial multi-bit subtractor controller. It sequences a single `full_subtractor` cell (ports `a`, `b`, `b_in`, `diff`, `borrow_out`) across a WIDTH-bit operand pair, LSB first, one bit per clock. It keeps the inter-bit borrow in a register and presents the registered result with a one-cycle done pulse. It sits between a requester that supplies operands with `start` and the shared 1-bit subtract cell, and is the first multi-cycle arithmetic block built on the lab's combinational cells.

## Interface
- `WIDTH`, default 8: operand/result width in bits; legal range 2..32.
- `clk` input 1: rising-edge clock; the only clock.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: request; sampled only in IDLE.
- `a` input WIDTH: minuend; latched on accepted `start`.
- `b` input WIDTH: subtrahend; latched on accepted `start`.
- `busy` output 1: high in RUN.
- `done` output 1: one-cycle pulse; result valid.
- `diff` output WIDTH: registered `a - b` modulo 2^WIDTH.
- `borrow_out` output 1: registered final borrow; 1 iff `a < b` unsigned.
- `ovf` output 1: signed overflow; present only with `SERIAL_SUB_OVF_EN`.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - On `start`=1, latch `a` and `b` into shift registers, clear the borrow register, set the bit counter to 0, and go to RUN.
  - On `start`=0, stay in IDLE.
- RUN:
  - Drive the cell with the LSB of the `a` shift register, the LSB of the `b` shift register, and the borrow register as `b_in`.
  - Each edge: shift the cell's `diff` into the MSB of the result shift register, shift both operand registers right by 1, load the cell's `borrow_out` into the borrow register, and increment the counter.
  - When the counter reaches WIDTH-1 at an edge, process that final bit, load the complete result into `diff`, load the final borrow into `borrow_out` (and `ovf`), and go to DONE.
- DONE: assert `done` for one cycle, then go to IDLE unconditionally.
- `start` is ignored in RUN and DONE. It is not queued.
- `a` and `b` may change freely after acceptance. Only the latched copies are used.
- `diff`, `borrow_out` and `ovf` change only at completion. They hold their values until the next completion or reset.
- Counter width is $clog2(WIDTH). There is no wrap-around: RUN exits at count WIDTH-1.
- Reset:
  - State goes to IDLE.
  - `busy`, `done`, `diff`, `borrow_out`, `ovf`, the counter, the borrow register and all shift registers go to 0.
- Reset asserted mid-RUN aborts the operation. Outputs read 0, not a partial result.

## Timing
- Edge E0: `start` sampled high in IDLE, operation accepted.
- After E0: `busy`=1 for exactly WIDTH cycles, covering edges E1..EWIDTH.
- Edge EWIDTH: results registered. `busy` falls and `done` rises.
- After EWIDTH: `done`=1 for exactly one cycle.
- Edge EWIDTH+1: return to IDLE. `start` sampled at this edge is ignored.
- Earliest next acceptance: EWIDTH+2.
- Latency: WIDTH+1 cycles from the accepting edge to `done` high. Throughput: one operation per WIDTH+2 cycles.
- `busy` and `done` are never high together.
- `start` held high continuously is accepted once per WIDTH+2 cycles.

## Configuration
- `SERIAL_SUB_OVF_EN` defined:
  - The `ovf` port exists.
  - `ovf` is registered at completion as (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), using the latched operand MSBs.
  - `ovf` resets to 0 and holds like `diff`.
- `SERIAL_SUB_OVF_EN` undefined: the `ovf` port and its logic are absent. All other behaviour is identical.

## Test plan
- WIDTH=8, `a`=0x5A, `b`=0x3C, `start` pulsed -> `busy` high for 8 cycles; `done` pulses 9 cycles after acceptance; `diff`=0x1E, `borrow_out`=0.
- `a`=0x00, `b`=0x01 -> `diff`=0xFF, `borrow_out`=1; `diff` holds 0xFF until the next completion.
- `a`=0x80, `b`=0x80, then `start` re-pulsed and `a`/`b` changed to 0xFF/0x00 while busy -> first result `diff`=0x00, `borrow_out`=0; no second operation accepted.
- `start` held high continuously with `a`=0x10, `b`=0x01 -> acceptances exactly 10 cycles apart; every result is `diff`=0x0F, `borrow_out`=0.
- `rst` asserted asynchronously 3 cycles into RUN with `a`=0x5A, `b`=0x3C -> `busy`, `done`, `diff` and `borrow_out` go to 0 immediately; `done` never pulses; a new `start` after reset gives `diff`=0x1E.
- With `SERIAL_SUB_OVF_EN`, `a`=0x80, `b`=0x01 -> `diff`=0x7F, `borrow_out`=0, `ovf`=1.
- With `SERIAL_SUB_OVF_EN`, `a`=0x05, `b`=0x03 -> `diff`=0x02, `ovf`=0.

Source files
------------

// File: rtl/serial_subtractor_ctrl_if.sv
// serial_subtractor_ctrl_if
// Request/result bundle between a requester and the bit-serial subtractor.
// The requester drives start/a/b; the subtractor returns busy/done and the
// registered result. The ovf signal exists only when SERIAL_SUB_OVF_EN is
// defined.

interface serial_subtractor_ctrl_if #(
    parameter int WIDTH = 8
);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow_out, ovf
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow_out, ovf
    );
`else
    modport master (
        output start, a, b,
        input  busy, done, diff, borrow_out
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow_out
    );
`endif

endinterface

// File: rtl/serial_subtractor_ctrl.sv
// serial_subtractor_ctrl
// Bit-serial WIDTH-bit subtractor: one full_subtractor cell is stepped across
// the latched operands LSB first, one bit per clock, with the inter-bit borrow
// kept in a register. The finished difference and final borrow are registered
// at completion and announced with a one-cycle done pulse.
// Optional feature macro: SERIAL_SUB_OVF_EN adds the signed-overflow flag ovf.
// WIDTH legal range: 2..32.

// Single-bit subtract cell: diff = a - b - b_in, borrow_out set on underflow.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic b_in,
    output logic diff,
    output logic borrow_out
);

    assign diff       = a ^ b ^ b_in;
    assign borrow_out = (~a & b) | (~(a ^ b) & b_in);

endmodule

module serial_subtractor_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    serial_subtractor_ctrl_if.slave  sub_if
);

    localparam int             CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [WIDTH-1:0]   res_sh_q, res_sh_d;
    logic               brw_q, brw_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               borrow_q, borrow_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
`ifdef SERIAL_SUB_OVF_EN
    // Operand MSBs are shifted out during RUN, so keep a copy for ovf.
    logic               a_msb_q, a_msb_d;
    logic               b_msb_q, b_msb_d;
    logic               ovf_q, ovf_d;
`endif

    logic               cell_a_s;
    logic               cell_b_s;
    logic               cell_diff_s;
    logic               cell_borrow_s;
    logic               last_bit_s;
    logic [WIDTH-1:0]   res_next_s;

    assign cell_a_s   = a_sh_q[0];
    assign cell_b_s   = b_sh_q[0];
    assign last_bit_s = (cnt_q == LAST_CNT);
    // The cell output enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
    assign res_next_s = {cell_diff_s, res_sh_q[WIDTH-1:1]};

    full_subtractor u_cell (
        .a          (cell_a_s),
        .b          (cell_b_s),
        .b_in       (brw_q),
        .diff       (cell_diff_s),
        .borrow_out (cell_borrow_s)
    );

    // Next-state logic: IDLE waits for start, RUN walks WIDTH bits, DONE lasts one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (sub_if.start) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_bit_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath next values: latch on accept, shift per bit, publish result on the last bit.
    always_comb begin
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_sh_d = res_sh_q;
        brw_d    = brw_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        ovf_d    = ovf_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (sub_if.start) begin
                    a_sh_d   = sub_if.a;
                    b_sh_d   = sub_if.b;
                    res_sh_d = {WIDTH{1'b0}};
                    brw_d    = 1'b0;
                    cnt_d    = {CNT_W{1'b0}};
`ifdef SERIAL_SUB_OVF_EN
                    a_msb_d  = sub_if.a[WIDTH-1];
                    b_msb_d  = sub_if.b[WIDTH-1];
`endif
                end else begin
                    // No request: everything holds its default.
                    cnt_d = cnt_q;
                end
            end
            ST_RUN: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                res_sh_d = res_next_s;
                brw_d    = cell_borrow_s;
                if (last_bit_s) begin
                    // Counter never wraps: park it at zero for the next operation.
                    cnt_d    = {CNT_W{1'b0}};
                    diff_d   = res_next_s;
                    borrow_d = cell_borrow_s;
`ifdef SERIAL_SUB_OVF_EN
                    ovf_d    = (a_msb_q != b_msb_q) && (cell_diff_s != a_msb_q);
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                // Result already registered; nothing moves.
                cnt_d = cnt_q;
            end
            default: begin
                cnt_d = {CNT_W{1'b0}};
            end
        endcase
    end

    // Status outputs are decoded from the next state so they register with it.
    always_comb begin
        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    // State and datapath registers; reset clears everything, aborting any RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            a_sh_q   <= {WIDTH{1'b0}};
            b_sh_q   <= {WIDTH{1'b0}};
            res_sh_q <= {WIDTH{1'b0}};
            brw_q    <= 1'b0;
            cnt_q    <= {CNT_W{1'b0}};
            diff_q   <= {WIDTH{1'b0}};
            borrow_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_sh_q <= res_sh_d;
            brw_q    <= brw_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign sub_if.busy       = busy_q;
    assign sub_if.done       = done_q;
    assign sub_if.diff       = diff_q;
    assign sub_if.borrow_out = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
    assign sub_if.ovf        = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// tb_serial_subtractor_ctrl
// Table-driven bench for the bit-serial subtractor (WIDTH=8) with a result
// scoreboard: expectations are queued when an operation is launched and
// compared when done pulses. Define SERIAL_SUB_OVF_EN to also check ovf.

module tb_serial_subtractor_ctrl;

    localparam int W = 8;

    logic clk;
    logic rst;

    serial_subtractor_ctrl_if #(.WIDTH(W)) sub_if ();

    serial_subtractor_ctrl #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .sub_if (sub_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       bo;
        logic       ov;
    } exp_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] d;
        logic       bo;
        logic       ov;
    } vec_t;

    exp_t sb_q[$];
    exp_t mon_e;
    vec_t vecs[12];

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [7:0] d, input logic bo, input logic ov);
        exp_t e;
        e.d  = d;
        e.bo = bo;
        e.ov = ov;
        sb_q.push_back(e);
    endtask

    // Scoreboard monitor: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst === 1'b0 && sub_if.done === 1'b1) begin
            done_cnt++;
            check("busy_with_done", 32'(sub_if.busy), 32'd0);
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got diff 0x%0h expected no completion", sub_if.diff);
            end else begin
                mon_e = sb_q.pop_front();
                check("diff", 32'(sub_if.diff), 32'(mon_e.d));
                check("borrow_out", 32'(sub_if.borrow_out), 32'(mon_e.bo));
`ifdef SERIAL_SUB_OVF_EN
                check("ovf", 32'(sub_if.ovf), 32'(mon_e.ov));
`endif
            end
        end
    end

    // One operation: pulse start, then measure busy length and done latency.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] d, input logic bo, input logic ov);
        int n;
        int busy_n;
        push_exp(d, bo, ov);
        @(negedge clk);
        sub_if.a     = a;
        sub_if.b     = b;
        sub_if.start = 1'b1;
        @(negedge clk);
        sub_if.start = 1'b0;
        n      = 1;
        busy_n = 0;
        while (sub_if.done !== 1'b1 && n < 40) begin
            if (sub_if.busy === 1'b1) busy_n++;
            @(negedge clk);
            n++;
        end
        check("done_latency", 32'(n), 32'd9);
        check("busy_cycles", 32'(busy_n), 32'd8);
    endtask

    initial begin
        int n;
        int dc0;
        int rises;
        int cyc;
        int t[3];
        logic prev_busy;

        vecs[0]  = '{a: 8'h5A, b: 8'h3C, d: 8'h1E, bo: 1'b0, ov: 1'b0};
        vecs[1]  = '{a: 8'h00, b: 8'h01, d: 8'hFF, bo: 1'b1, ov: 1'b0};
        vecs[2]  = '{a: 8'h80, b: 8'h80, d: 8'h00, bo: 1'b0, ov: 1'b0};
        vecs[3]  = '{a: 8'h10, b: 8'h01, d: 8'h0F, bo: 1'b0, ov: 1'b0};
        vecs[4]  = '{a: 8'hFF, b: 8'hFF, d: 8'h00, bo: 1'b0, ov: 1'b0};
        vecs[5]  = '{a: 8'h01, b: 8'hFF, d: 8'h02, bo: 1'b1, ov: 1'b0};
        vecs[6]  = '{a: 8'h80, b: 8'h01, d: 8'h7F, bo: 1'b0, ov: 1'b1};
        vecs[7]  = '{a: 8'h05, b: 8'h03, d: 8'h02, bo: 1'b0, ov: 1'b0};
        vecs[8]  = '{a: 8'h7F, b: 8'h80, d: 8'hFF, bo: 1'b1, ov: 1'b1};
        vecs[9]  = '{a: 8'h00, b: 8'h00, d: 8'h00, bo: 1'b0, ov: 1'b0};
        vecs[10] = '{a: 8'hA3, b: 8'h5C, d: 8'h47, bo: 1'b0, ov: 1'b1};
        vecs[11] = '{a: 8'hFF, b: 8'h00, d: 8'hFF, bo: 1'b0, ov: 1'b0};

        // Reset state.
        rst          = 1'b1;
        sub_if.start = 1'b0;
        sub_if.a     = 8'h00;
        sub_if.b     = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(sub_if.busy), 32'd0);
        check("rst_done", 32'(sub_if.done), 32'd0);
        check("rst_diff", 32'(sub_if.diff), 32'd0);
        check("rst_borrow", 32'(sub_if.borrow_out), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        check("rst_ovf", 32'(sub_if.ovf), 32'd0);
`endif
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Table of single operations.
        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].bo, vecs[i].ov);
        end

        // Result holds until the next completion.
        run_op(8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);
        repeat (6) @(negedge clk);
        check("hold_diff", 32'(sub_if.diff), 32'hFF);
        check("hold_borrow", 32'(sub_if.borrow_out), 32'd1);

        // start re-pulsed and operands changed while busy: ignored.
        dc0 = done_cnt;
        push_exp(8'h00, 1'b0, 1'b0);
        @(negedge clk);
        sub_if.a     = 8'h80;
        sub_if.b     = 8'h80;
        sub_if.start = 1'b1;
        @(negedge clk);
        sub_if.start = 1'b0;
        repeat (2) @(negedge clk);
        sub_if.start = 1'b1;
        sub_if.a     = 8'hFF;
        sub_if.b     = 8'h00;
        repeat (3) @(negedge clk);
        sub_if.start = 1'b0;
        n = 0;
        while (sub_if.done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        repeat (15) @(negedge clk);
        check("single_accept", 32'(done_cnt - dc0), 32'd1);

        // start held high: one acceptance every WIDTH+2 cycles.
        for (int i = 0; i < 3; i++) push_exp(8'h0F, 1'b0, 1'b0);
        @(negedge clk);
        sub_if.a     = 8'h10;
        sub_if.b     = 8'h01;
        sub_if.start = 1'b1;
        rises     = 0;
        cyc       = 0;
        prev_busy = sub_if.busy;
        while (rises < 3 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (sub_if.busy === 1'b1 && prev_busy !== 1'b1) begin
                t[rises] = cyc;
                rises++;
            end
            prev_busy = sub_if.busy;
        end
        sub_if.start = 1'b0;
        check("held_accepts", 32'(rises), 32'd3);
        check("held_gap_1", 32'(t[1] - t[0]), 32'd10);
        check("held_gap_2", 32'(t[2] - t[1]), 32'd10);
        n = 0;
        while (sb_q.size() != 0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("held_drained", 32'(sb_q.size()), 32'd0);

        // Asynchronous reset mid-RUN aborts the operation.
        repeat (2) @(negedge clk);
        dc0 = done_cnt;
        sub_if.a     = 8'h5A;
        sub_if.b     = 8'h3C;
        sub_if.start = 1'b1;
        @(negedge clk);
        sub_if.start = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", 32'(sub_if.busy), 32'd0);
        check("abort_done", 32'(sub_if.done), 32'd0);
        check("abort_diff", 32'(sub_if.diff), 32'd0);
        check("abort_borrow", 32'(sub_if.borrow_out), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        check("abort_no_done", 32'(done_cnt - dc0), 32'd0);
        run_op(8'h5A, 8'h3C, 8'h1E, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
